// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared state encodings and stage-control vectors for cpu_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

   localparam int CTRL_STATE_BUS = 2;

   typedef enum logic [CTRL_STATE_BUS-1:0] {
      CTRL_STATE_IDLE  = 2'd0,
      CTRL_STATE_RUN   = 2'd1,
      CTRL_STATE_DRAIN = 2'd2,
      CTRL_STATE_HALT  = 2'd3
   } ctrl_state_e;

   localparam int STAGE_PC    = 0;
   localparam int STAGE_IFID  = 1;
   localparam int STAGE_IDEX  = 2;
   localparam int STAGE_EXMEM = 3;
   localparam int STAGE_MEMWB = 4;
   localparam int STAGE_BUS   = 5;

   typedef logic [STAGE_BUS-1:0] stage_vec_t;

   // Canned hold/bubble patterns, bit index = STAGE_* above.
   localparam stage_vec_t STAGE_NONE      = 5'b00000;
   localparam stage_vec_t STAGE_ALL       = 5'b11111;
   localparam stage_vec_t MEMBUSY_STALL   = 5'b01111;
   localparam stage_vec_t MEMBUSY_FLUSH   = 5'b10000;
   localparam stage_vec_t BUBBLE_ID_STALL = 5'b00011;
   localparam stage_vec_t BUBBLE_ID_FLUSH = 5'b00100;
   localparam stage_vec_t BRANCH_FLUSH    = 5'b00110;

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_hazard.sv
// ============================================================================
// Module   : cpu_ctrl_hazard
// Purpose  : Combinational load-use detector (EX load vs. ID source regs).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_ctrl_hazard (
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_waddr_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   output logic       load_use_o
);

   logic w_rs_match;

   // x0 is never a real dependency.
   assign w_rs_match = (ex_waddr_i == rs1_i) || (ex_waddr_i == rs2_i);
   assign load_use_o = ex_is_load_i && (ex_waddr_i != 5'd0) && w_rs_match;

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
// Module   : cpu_ctrl
// Purpose  : 5-stage pipeline sequencer: stall/flush generation, drain & halt.
//            Optional perf counters enabled by macro CPU_CTRL_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 halt_req_i,
   input  logic                 id_valid_i,
   input  logic                 id_error_i,
   input  logic [31:0]          id_pc_i,
   input  logic [31:0]          id_instr_i,
   input  logic [4:0]           id_rs1_i,
   input  logic [4:0]           id_rs2_i,
   input  logic                 ex_is_load_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic                 ex_branch_taken_i,
   input  logic                 mem_busy_i,
   output logic [4:0]           stall_o,
   output logic [4:0]           flush_o,
   output logic                 halted_o,
   output logic                 error_o,
   output logic [31:0]          err_pc_o,
   output logic [31:0]          err_instr_o,
   output logic [CNT_WIDTH-1:0] cycle_cnt_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] c_DRAIN_LOAD = DW'(DRAIN_CYCLES);
   localparam logic [DW-1:0] c_ONE        = DW'(1);

   ctrl_state_e   r_state;
   ctrl_state_e   w_state_nxt;
   logic [DW-1:0] r_drain_cnt;
   logic [DW-1:0] w_drain_nxt;
   stage_vec_t    w_stall;
   stage_vec_t    w_flush;
   logic          w_capture;
   logic          w_load_use;
   logic          r_halted;
   logic          r_error;
   logic [31:0]   r_err_pc;
   logic [31:0]   r_err_instr;

   cpu_ctrl_hazard u_hazard (
      .ex_is_load_i (ex_is_load_i),
      .ex_waddr_i   (ex_waddr_i),
      .rs1_i        (id_rs1_i),
      .rs2_i        (id_rs2_i),
      .load_use_o   (w_load_use)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      w_stall     = STAGE_NONE;
      w_flush     = STAGE_NONE;
      w_capture   = 1'b0;
      case (r_state)
         CTRL_STATE_IDLE: begin
            w_stall = STAGE_ALL;
            if (start_i) w_state_nxt = CTRL_STATE_RUN;
         end
         CTRL_STATE_RUN: begin
            if (mem_busy_i) begin
               w_stall = MEMBUSY_STALL;
               w_flush = MEMBUSY_FLUSH;
            end else if (ex_branch_taken_i) begin
               w_flush = BRANCH_FLUSH;
            end else if ((id_valid_i && id_error_i) || halt_req_i) begin
               // Error wins over halt request; both start the drain identically.
               w_stall     = BUBBLE_ID_STALL;
               w_flush     = BUBBLE_ID_FLUSH;
               w_capture   = id_valid_i && id_error_i;
               w_drain_nxt = c_DRAIN_LOAD;
               w_state_nxt = (DRAIN_CYCLES == 0) ? CTRL_STATE_HALT : CTRL_STATE_DRAIN;
            end else if (w_load_use) begin
               w_stall = BUBBLE_ID_STALL;
               w_flush = BUBBLE_ID_FLUSH;
            end
         end
         CTRL_STATE_DRAIN: begin
            if (mem_busy_i) begin
               w_stall = MEMBUSY_STALL;
               w_flush = MEMBUSY_FLUSH;
            end else begin
               w_stall     = BUBBLE_ID_STALL;
               w_flush     = BUBBLE_ID_FLUSH;
               w_drain_nxt = r_drain_cnt - c_ONE;
               if (r_drain_cnt <= c_ONE) w_state_nxt = CTRL_STATE_HALT;
            end
         end
         CTRL_STATE_HALT: begin
            w_stall = STAGE_ALL;
         end
         default: begin
            w_stall     = STAGE_ALL;
            w_state_nxt = CTRL_STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= CTRL_STATE_IDLE;
         r_drain_cnt <= '0;
         r_halted    <= 1'b0;
         r_error     <= 1'b0;
         r_err_pc    <= '0;
         r_err_instr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
         r_halted    <= (w_state_nxt == CTRL_STATE_HALT);
         if (w_capture) begin
            r_error     <= 1'b1;
            r_err_pc    <= id_pc_i;
            r_err_instr <= id_instr_i;
         end
      end
   end

   assign stall_o     = w_stall;
   assign flush_o     = w_flush;
   assign halted_o    = r_halted;
   assign error_o     = r_error;
   assign err_pc_o    = r_err_pc;
   assign err_instr_o = r_err_instr;

`ifdef CPU_CTRL_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

   logic                 w_active;
   logic [CNT_WIDTH-1:0] r_cycle_cnt;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   assign w_active = (r_state == CTRL_STATE_RUN) || (r_state == CTRL_STATE_DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
         r_stall_cnt <= '0;
      end else if (w_active) begin
         r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
         if (w_stall[STAGE_PC]) r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
   end

   assign cycle_cnt_o = r_cycle_cnt;
   assign stall_cnt_o = r_stall_cnt;
`else
   assign cycle_cnt_o = '0;
   assign stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ============================================================================
// Module   : tb_cpu_ctrl
// Purpose  : Self-checking bench for cpu_ctrl against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl;

   localparam int DRAIN = 3;
   localparam int CW    = 32;

   logic          clk;
   logic          rst_n;
   logic          start_i, halt_req_i, id_valid_i, id_error_i;
   logic [31:0]   id_pc_i, id_instr_i;
   logic [4:0]    id_rs1_i, id_rs2_i, ex_waddr_i;
   logic          ex_is_load_i, ex_branch_taken_i, mem_busy_i;
   logic [4:0]    stall_o, flush_o;
   logic          halted_o, error_o;
   logic [31:0]   err_pc_o, err_instr_o;
   logic [CW-1:0] cycle_cnt_o, stall_cnt_o;

   int n_cmp;
   int n_err;

   // Reference model: spec-level phase name, remaining drain cycles, latched results.
   string       m_phase;
   int          m_left;
   logic        m_halt, m_err;
   logic [31:0] m_pc, m_instr, m_cyc, m_stc;

   cpu_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_i           (start_i),
      .halt_req_i        (halt_req_i),
      .id_valid_i        (id_valid_i),
      .id_error_i        (id_error_i),
      .id_pc_i           (id_pc_i),
      .id_instr_i        (id_instr_i),
      .id_rs1_i          (id_rs1_i),
      .id_rs2_i          (id_rs2_i),
      .ex_is_load_i      (ex_is_load_i),
      .ex_waddr_i        (ex_waddr_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .mem_busy_i        (mem_busy_i),
      .stall_o           (stall_o),
      .flush_o           (flush_o),
      .halted_o          (halted_o),
      .error_o           (error_o),
      .err_pc_o          (err_pc_o),
      .err_instr_o       (err_instr_o),
      .cycle_cnt_o       (cycle_cnt_o),
      .stall_cnt_o       (stall_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      start_i = 0; halt_req_i = 0; id_valid_i = 0; id_error_i = 0;
      id_pc_i = 0; id_instr_i = 0; id_rs1_i = 0; id_rs2_i = 0;
      ex_is_load_i = 0; ex_waddr_i = 0; ex_branch_taken_i = 0; mem_busy_i = 0;
   endtask

   task automatic model_reset();
      m_phase = "IDLE"; m_left = 0; m_halt = 0; m_err = 0;
      m_pc = 0; m_instr = 0; m_cyc = 0; m_stc = 0;
   endtask

   function automatic logic [9:0] model_ctl();
      logic lu;
      lu = ex_is_load_i && ex_waddr_i != 0 && (ex_waddr_i == id_rs1_i || ex_waddr_i == id_rs2_i);
      if (m_phase == "IDLE" || m_phase == "HALT") return {5'b11111, 5'b00000};
      if (mem_busy_i) return {5'b01111, 5'b10000};
      if (m_phase == "DRAIN") return {5'b00011, 5'b00100};
      if (ex_branch_taken_i) return {5'b00000, 5'b00110};
      if ((id_valid_i && id_error_i) || halt_req_i || lu) return {5'b00011, 5'b00100};
      return 10'd0;
   endfunction

   task automatic model_edge();
      logic [9:0] ctl;
      ctl = model_ctl();
      if (m_phase == "RUN" || m_phase == "DRAIN") begin
         m_cyc = m_cyc + 1;
         if (ctl[5]) m_stc = m_stc + 1;
      end
      if (m_phase == "IDLE") begin
         if (start_i) m_phase = "RUN";
      end else if (m_phase == "RUN") begin
         if (!mem_busy_i && !ex_branch_taken_i &&
             ((id_valid_i && id_error_i) || halt_req_i)) begin
            if (id_valid_i && id_error_i) begin
               m_err = 1; m_pc = id_pc_i; m_instr = id_instr_i;
            end
            m_left  = DRAIN;
            m_phase = (DRAIN == 0) ? "HALT" : "DRAIN";
         end
      end else if (m_phase == "DRAIN") begin
         if (!mem_busy_i) begin
            m_left--;
            if (m_left == 0) m_phase = "HALT";
         end
      end
      m_halt = (m_phase == "HALT");
   endtask

   task automatic chk_regs(input string tag);
`ifdef CPU_CTRL_PERF_CNT_EN
      chk({tag, ".cyc"}, cycle_cnt_o, m_cyc);
      chk({tag, ".stc"}, stall_cnt_o, m_stc);
`else
      chk({tag, ".cyc"}, cycle_cnt_o, 0);
      chk({tag, ".stc"}, stall_cnt_o, 0);
`endif
      chk({tag, ".halted"}, halted_o, m_halt);
      chk({tag, ".error"}, error_o, m_err);
      chk({tag, ".err_pc"}, err_pc_o, m_pc);
      chk({tag, ".err_instr"}, err_instr_o, m_instr);
   endtask

   // Check at the negedge, then advance one clock and update the model.
   task automatic step(input string tag);
      logic [9:0] ctl;
      @(negedge clk);
      ctl = model_ctl();
      chk({tag, ".stall"}, stall_o, ctl[9:5]);
      chk({tag, ".flush"}, flush_o, ctl[4:0]);
      chk_regs(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".stall"}, stall_o, 5'b11111);
      chk({tag, ".flush"}, flush_o, 5'b00000);
      chk({tag, ".halted"}, halted_o, 1'b0);
      chk({tag, ".error"}, error_o, 1'b0);
      chk({tag, ".err_pc"}, err_pc_o, 32'd0);
      chk({tag, ".err_instr"}, err_instr_o, 32'd0);
      chk({tag, ".cyc"}, cycle_cnt_o, 0);
      chk({tag, ".stc"}, stall_cnt_o, 0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #3 chk_reset("por");
      @(posedge clk);
      #1 rst_n = 1'b1;

      step("idle");
      start_i = 1; step("start_edge"); start_i = 0;
      step("run_first");

      ex_is_load_i = 1; ex_waddr_i = 5; id_rs1_i = 1; id_rs2_i = 5;
      step("lu_rs2");
      ex_waddr_i = 0; id_rs2_i = 0; id_rs1_i = 0;
      step("lu_x0");
      clear_inputs();

      ex_branch_taken_i = 1; id_valid_i = 1; id_error_i = 1;
      step("br_err");
      clear_inputs();
      step("post_br");
      chk("post_br.error_const", error_o, 1'b0);

      for (int i = 0; i < 150; i++) begin
         mem_busy_i        = ($urandom_range(0, 3) == 0);
         ex_branch_taken_i = ($urandom_range(0, 5) == 0);
         id_valid_i        = $urandom_range(0, 1);
         id_error_i        = $urandom_range(0, 1);
         halt_req_i        = $urandom_range(0, 1);
         ex_is_load_i      = $urandom_range(0, 1);
         ex_waddr_i        = 5'($urandom_range(0, 7));
         id_rs1_i          = 5'($urandom_range(0, 7));
         id_rs2_i          = 5'($urandom_range(0, 7));
         id_pc_i           = $urandom;
         id_instr_i        = $urandom;
         // Only let error/halt through when masked by higher priority, so RUN continues.
         if (!mem_busy_i && !ex_branch_taken_i) begin
            halt_req_i = 0;
            if (id_valid_i) id_error_i = 0;
         end
         step("rand_run");
      end
      clear_inputs();

      id_valid_i = 1; id_error_i = 1; id_pc_i = 32'h8000_0010; id_instr_i = 32'hFFFF_FFFF;
      step("err_enter");
      clear_inputs();
      chk("err.pc_const", err_pc_o, 32'h8000_0010);
      chk("err.error_const", error_o, 1'b1);
      step("drain1");
      mem_busy_i = 1; ex_branch_taken_i = 1; id_valid_i = 1; id_error_i = 1; id_pc_i = 32'h1234;
      step("drain_busy1");
      step("drain_busy2");
      clear_inputs();
      step("drain2");
      chk("drain2.not_halted", halted_o, 1'b0);
      step("drain3");
      chk("halt.halted_const", halted_o, 1'b1);
      chk("halt.err_pc_hold", err_pc_o, 32'h8000_0010);
      start_i = 1; halt_req_i = 1;
      step("halt_ignore1");
      step("halt_ignore2");
      clear_inputs();

      #1 rst_n = 1'b0;
      #1 chk_reset("async_halt");
      model_reset();
      #1 rst_n = 1'b1;

      start_i = 1; step("start2"); start_i = 0;
      halt_req_i = 1; step("hreq"); halt_req_i = 0;
      step("hdrain");
      #1 rst_n = 1'b0;
      #1 chk_reset("async_drain");
      model_reset();
      #1 rst_n = 1'b1;

      start_i = 1; step("start3"); start_i = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            ex_is_load_i = 1; ex_waddr_i = 7; id_rs1_i = 7;
         end else begin
            clear_inputs();
         end
         step("perf_run");
      end
      clear_inputs();
      @(negedge clk);
`ifdef CPU_CTRL_PERF_CNT_EN
      chk("perf.cycle_cnt", cycle_cnt_o, 10);
      chk("perf.stall_cnt", stall_cnt_o, 1);
`else
      chk("perf.cycle_cnt", cycle_cnt_o, 0);
      chk("perf.stall_cnt", stall_cnt_o, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB). It takes the decode-error, load-use, branch-redirect and memory-busy conditions and produces per-stage stall and flush vectors. It drains the pipe and halts the core on an illegal instruction or an external halt request. It sits beside the pipeline registers and drives their hold/bubble controls.

Parameters:
DRAIN_CYCLES, 3, cycles spent letting older instructions (EX, MEM, WB) retire before HALT.
CNT_WIDTH, 32, width of the performance counters.

Ports:
clk  in  1  core clock.
rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
start_i  in  1  leave IDLE and begin fetching.
halt_req_i  in  1  external request to drain and halt.
id_valid_i  in  1  ID slot holds a real instruction.
id_error_i  in  1  decoder flags an illegal instruction (combinational, from id).
id_pc_i  in  32  PC of the instruction in ID.
id_instr_i  in  32  instruction word in ID.
id_rs1_i  in  5  ID read address 1.
id_rs2_i  in  5  ID read address 2.
ex_is_load_i  in  1  instruction in EX is a load.
ex_waddr_i  in  5  destination register of EX.
ex_branch_taken_i  in  1  EX resolves a taken branch or jump.
mem_busy_i  in  1  data memory has not completed this cycle.
stall_o  out  5  hold bits: [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB.
flush_o  out  5  bubble-insert bits, same indexing as stall_o.
halted_o  out  1  core is in HALT.
error_o  out  1  halt was caused by an illegal instruction.
err_pc_o  out  32  captured PC of the faulting instruction.
err_instr_o  out  32  captured faulting instruction word.
cycle_cnt_o  out  CNT_WIDTH  cycles spent in RUN or DRAIN.
stall_cnt_o  out  CNT_WIDTH  cycles with stall_o[0] set in RUN or DRAIN.

Behaviour:
- State machine: IDLE, RUN, DRAIN, HALT. Registered state; stall_o and flush_o are combinational from the state and the inputs.
- Reset values: state=IDLE, drain counter=0, halted_o=0, error_o=0, err_pc_o=0, err_instr_o=0, counters=0.
- IDLE: stall=11111, flush=00000. Goes to RUN on the first clock edge where start_i=1.
- RUN, per cycle, in strict priority order:
  1. mem_busy_i: stall=01111, flush=10000.
  2. ex_branch_taken_i: stall=00000, flush=00110. A wrong-path id_error_i in the same cycle is ignored.
  3. id_valid_i and id_error_i: stall=00011, flush=00100. Latch id_pc_i into err_pc_o and id_instr_i into err_instr_o, set error_o at the next edge, load counter=DRAIN_CYCLES, go to DRAIN.
  4. halt_req_i: same controls as item 3, but no capture and error_o stays 0; go to DRAIN. If item 3 and item 4 coincide, item 3 applies.
  5. Load-use: ex_is_load_i, ex_waddr_i!=0, and ex_waddr_i equals id_rs1_i or id_rs2_i. Result stall=00011, flush=00100, lasting exactly one cycle because the load leaves EX.
  6. Otherwise stall=00000, flush=00000.
- DRAIN: stall=00011, flush=00100; the counter decrements each cycle.
  - If mem_busy_i: stall=01111, flush=10000, counter holds.
  - Branch and error inputs are ignored.
  - When the counter is 1 and decrements, go to HALT at that edge.
  - DRAIN_CYCLES=0 goes straight to HALT.
- HALT: stall=11111, flush=00000, halted_o=1 (registered, from the entry edge). Terminal until reset; start_i and halt_req_i are ignored.
- err_pc_o and err_instr_o are written only on the error transition and hold until reset.
- Reset asserted mid-DRAIN or mid-stall returns everything to the reset values immediately (asynchronous).

Optional Feature:
CPU_CTRL_PERF_CNT_EN.
- Defined: cycle_cnt_o and stall_cnt_o are registered counters, enabled in RUN and DRAIN, that wrap modulo 2^CNT_WIDTH and freeze in HALT.
- Undefined: both ports are tied to 0 and no counter flops are built. The port list is unchanged.

Decomposition:
- common.v gains: CTRL_STATE_IDLE/RUN/DRAIN/HALT encodings (2-bit), CTRL_STATE_BUS, STAGE_PC/IFID/IDEX/EXMEM/MEMWB bit indices, STAGE_BUS [4:0].
- One sub-module, cpu_ctrl_hazard: the combinational load-use compare (ex_is_load, ex_waddr, rs1, rs2 -> load_use). It is reused later for forwarding.

Test Plan:
- Reset, then start_i pulse -> IDLE stall=11111; stall=00000 the cycle after the start edge; halted_o=0.
- Load to x5 in EX, ID reads rs2=5 -> stall=00011, flush=00100 for one cycle. With ex_waddr_i=0 -> no stall.
- ex_branch_taken_i=1 together with id_error_i=1 -> flush=00110, error_o stays 0, state stays RUN.
- id_error_i with pc=0x80000010, instr=0xFFFFFFFF -> error_o=1 next cycle, err_pc_o=0x80000010; halted_o=1 after 3 drain cycles.
- mem_busy_i high for 2 cycles during DRAIN -> stall=01111 and the counter holds; HALT is reached after 3+2 cycles.
- Perf build: 10 RUN cycles with one load-use stall -> cycle_cnt_o=10, stall_cnt_o=1. Non-perf build -> both read 0.
